// File: rtl/i2c_wb_sequencer_if.sv
// WISHBONE link between the I2C sequencer (master) and the i2c_master_top core (slave).
interface i2c_wb_sequencer_if;
  logic       wb_cyc_o;
  logic       wb_stb_o;
  logic       wb_we_o;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_ack_i;

  modport master (output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
                  input  wb_dat_i, wb_ack_i);
  modport slave  (input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
                  output wb_dat_i, wb_ack_i);
endinterface

// File: rtl/i2c_wb_sequencer.sv
// I2C transaction sequencer: configures the WISHBONE I2C master core, then
// serves two hardware requesters round-robin with full register-level sequences.
module i2c_wb_sequencer #(
  parameter logic [15:0] PRESCALE = 16'd199,
  parameter logic [15:0] TIMEOUT  = 16'd4095
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [1:0]  req_i,
  input  logic [13:0] req_addr_i,
  input  logic [1:0]  req_rnw_i,
  input  logic [3:0]  req_len_i,
  input  logic [63:0] req_wdat_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  done_o,
  output logic [1:0]  err_o,
  output logic [31:0] rdat_o,
  output logic        init_done_o,
  output logic        busy_o,
  i2c_wb_sequencer_if.master wb
);

  typedef enum logic [3:0] {
    S_INIT_PRLO, S_INIT_PRHI, S_INIT_CTR, S_IDLE, S_ADDR_TXR, S_ADDR_CR, S_POLL,
    S_WR_TXR, S_WR_CR, S_RD_CR, S_RD_RXR, S_STOP, S_STOP_WAIT, S_DONE
  } state_t;
  typedef enum logic [1:0] {PH_ADDR, PH_WR, PH_RD} phase_t;

  state_t      r_state, w_nstate;
  phase_t      r_phase;
  logic        r_cyc, r_we;
  logic [2:0]  r_adr;
  logic [7:0]  r_dat;
  logic        r_g, r_last, r_rnw, r_err, r_init, r_busy;
  logic [6:0]  r_addr;
  logic [1:0]  r_len, r_idx, r_gnt, r_done, r_erro;
  logic [31:0] r_wdat, r_rdat;
  logic [15:0] r_poll;

  logic        w_start, w_we, w_done, w_last, w_pick, w_grant;
  logic        w_set_err, w_poll_inc, w_idx_inc, w_rd_store;
  logic [2:0]  w_adr;
  logic [7:0]  w_dat, w_sr, w_txbyte;
  logic [1:0]  w_req;

  assign w_done   = r_cyc & wb.wb_ack_i;
  assign w_sr     = wb.wb_dat_i;
  assign w_last   = (r_idx == r_len);
  assign w_txbyte = r_wdat[{r_idx, 3'b000} +: 8];
  // requests still held during the done pulse belong to the finished transaction
  assign w_req    = req_i & ~r_done;
  assign w_pick   = (&w_req) ? ~r_last : w_req[1];

  assign wb.wb_cyc_o = r_cyc;
  assign wb.wb_stb_o = r_cyc;
  assign wb.wb_we_o  = r_we;
  assign wb.wb_adr_o = r_adr;
  assign wb.wb_dat_o = r_dat;
  assign gnt_o       = r_gnt;
  assign done_o      = r_done;
  assign err_o       = r_erro;
  assign rdat_o      = r_rdat;
  assign init_done_o = r_init;
  assign busy_o      = r_busy;

  // state register
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) r_state <= S_INIT_PRLO;
    else          r_state <= w_nstate;

  // next state and the bus access each state wants; a new access starts only
  // once cyc is low, which yields the idle cycle after every ack
  always_comb begin
    w_nstate = r_state; w_start = 1'b0; w_we = 1'b0; w_adr = 3'd0; w_dat = 8'h00;
    w_grant = 1'b0; w_set_err = 1'b0; w_poll_inc = 1'b0; w_idx_inc = 1'b0; w_rd_store = 1'b0;
    case (r_state)
      S_INIT_PRLO: begin
        w_start = ~r_cyc; w_we = 1'b1; w_adr = 3'd0; w_dat = PRESCALE[7:0];
        if (w_done) w_nstate = S_INIT_PRHI;
      end
      S_INIT_PRHI: begin
        w_start = ~r_cyc; w_we = 1'b1; w_adr = 3'd1; w_dat = PRESCALE[15:8];
        if (w_done) w_nstate = S_INIT_CTR;
      end
      S_INIT_CTR: begin
        w_start = ~r_cyc; w_we = 1'b1; w_adr = 3'd2; w_dat = 8'h80;
        if (w_done) w_nstate = S_IDLE;
      end
      S_IDLE: if (|w_req) begin w_grant = 1'b1; w_nstate = S_ADDR_TXR; end
      S_ADDR_TXR: begin
        w_start = ~r_cyc; w_we = 1'b1; w_adr = 3'd3; w_dat = {r_addr, r_rnw};
        if (w_done) w_nstate = S_ADDR_CR;
      end
      S_ADDR_CR: begin
        w_start = ~r_cyc; w_we = 1'b1; w_adr = 3'd4; w_dat = 8'h90;
        if (w_done) w_nstate = S_POLL;
      end
      S_POLL: begin
        w_start = ~r_cyc; w_adr = 3'd4;
        if (w_done) begin
          if (w_sr[1]) begin
            if (r_poll == TIMEOUT) begin w_set_err = 1'b1; w_nstate = S_STOP; end
            else w_poll_inc = 1'b1;
          end else if (w_sr[5]) begin
            // arbitration lost: the core has already released the bus
            w_set_err = 1'b1; w_nstate = S_DONE;
          end else begin
            case (r_phase)
              PH_ADDR:
                if (w_sr[7]) begin w_set_err = 1'b1; w_nstate = S_STOP; end
                else w_nstate = r_rnw ? S_RD_CR : S_WR_TXR;
              PH_WR:
                if (w_last) begin
                  if (w_sr[7]) begin w_set_err = 1'b1; w_nstate = S_DONE; end
                  else w_nstate = S_STOP_WAIT;
                end else if (w_sr[7]) begin w_set_err = 1'b1; w_nstate = S_STOP; end
                else begin w_idx_inc = 1'b1; w_nstate = S_WR_TXR; end
              default: w_nstate = S_RD_RXR;
            endcase
          end
        end
      end
      S_WR_TXR: begin
        w_start = ~r_cyc; w_we = 1'b1; w_adr = 3'd3; w_dat = w_txbyte;
        if (w_done) w_nstate = S_WR_CR;
      end
      S_WR_CR: begin
        w_start = ~r_cyc; w_we = 1'b1; w_adr = 3'd4; w_dat = w_last ? 8'h50 : 8'h10;
        if (w_done) w_nstate = S_POLL;
      end
      S_RD_CR: begin
        w_start = ~r_cyc; w_we = 1'b1; w_adr = 3'd4; w_dat = w_last ? 8'h68 : 8'h20;
        if (w_done) w_nstate = S_POLL;
      end
      S_RD_RXR: begin
        w_start = ~r_cyc; w_adr = 3'd3;
        if (w_done) begin
          w_rd_store = 1'b1;
          if (w_last) w_nstate = S_STOP_WAIT;
          else begin w_idx_inc = 1'b1; w_nstate = S_RD_CR; end
        end
      end
      S_STOP: begin
        w_start = ~r_cyc; w_we = 1'b1; w_adr = 3'd4; w_dat = 8'h40;
        if (w_done) w_nstate = S_STOP_WAIT;
      end
      S_STOP_WAIT: begin
        w_start = ~r_cyc; w_adr = 3'd4;
        if (w_done) begin
          if (!w_sr[6]) w_nstate = S_DONE;
          else if (r_poll == TIMEOUT) begin w_set_err = 1'b1; w_nstate = S_DONE; end
          else w_poll_inc = 1'b1;
        end
      end
      S_DONE:  w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // WISHBONE master registers: launch on start, drop everything after the ack edge
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_cyc <= 1'b0; r_we <= 1'b0; r_adr <= 3'd0; r_dat <= 8'h00;
    end else if (w_start) begin
      r_cyc <= 1'b1; r_we <= w_we; r_adr <= w_adr; r_dat <= w_dat;
    end else if (w_done) begin
      r_cyc <= 1'b0; r_we <= 1'b0; r_adr <= 3'd0; r_dat <= 8'h00;
    end

  // transaction datapath: grant/latch, poll counter, byte index, read data, status pulses
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_phase <= PH_ADDR; r_g <= 1'b0; r_last <= 1'b1; r_rnw <= 1'b0; r_err <= 1'b0;
      r_init <= 1'b0; r_busy <= 1'b0; r_addr <= 7'd0; r_len <= 2'd0; r_idx <= 2'd0;
      r_gnt <= 2'b00; r_done <= 2'b00; r_erro <= 2'b00; r_wdat <= 32'd0; r_rdat <= 32'd0;
      r_poll <= 16'd0;
    end else begin
      r_busy <= (w_nstate != S_IDLE);
      r_done <= 2'b00;
      r_erro <= 2'b00;
      if (w_done && r_state == S_INIT_CTR) r_init <= 1'b1;
      if (w_grant) begin
        r_g    <= w_pick;
        r_gnt  <= w_pick ? 2'b10 : 2'b01;
        r_addr <= w_pick ? req_addr_i[13:7] : req_addr_i[6:0];
        r_rnw  <= req_rnw_i[w_pick];
        r_len  <= w_pick ? req_len_i[3:2] : req_len_i[1:0];
        r_wdat <= w_pick ? req_wdat_i[63:32] : req_wdat_i[31:0];
        r_rdat <= 32'd0; r_err <= 1'b0; r_idx <= 2'd0;
      end
      if (w_done && r_state == S_ADDR_CR) r_phase <= PH_ADDR;
      if (w_done && r_state == S_WR_CR)   r_phase <= PH_WR;
      if (w_done && r_state == S_RD_CR)   r_phase <= PH_RD;
      // every control-register write restarts the poll budget
      if (w_done && r_we && r_adr == 3'd4) r_poll <= 16'd0;
      else if (w_poll_inc)                 r_poll <= r_poll + 16'd1;
      if (w_idx_inc)  r_idx <= r_idx + 2'd1;
      if (w_set_err)  r_err <= 1'b1;
      if (w_rd_store) r_rdat[{r_idx, 3'b000} +: 8] <= w_sr;
      if (r_state == S_DONE) begin
        r_done[r_g] <= 1'b1;
        r_erro[r_g] <= r_err;
        r_gnt       <= 2'b00;
        r_last      <= r_g;
      end
    end

endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// Directed bench: a WISHBONE core model with zero-latency ack, a log of every
// accepted bus access, and hand-built expected access lists per transaction.
module tb_i2c_wb_sequencer;
  localparam logic [15:0] TMO = 16'd10;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [1:0]  req = '0, rnw = '0;
  logic [13:0] addr = '0;
  logic [3:0]  len = '0;
  logic [63:0] wdat = '0;
  logic [1:0]  gnt, done, err;
  logic [31:0] rdat;
  logic        init_done, busy;

  always #5 clk = ~clk;

  i2c_wb_sequencer_if wb();

  i2c_wb_sequencer #(.PRESCALE(16'd199), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .req_addr_i(addr), .req_rnw_i(rnw),
    .req_len_i(len), .req_wdat_i(wdat), .gnt_o(gnt), .done_o(done), .err_o(err),
    .rdat_o(rdat), .init_done_o(init_done), .busy_o(busy), .wb(wb)
  );

  // core model
  logic [7:0]  sr_val = 8'h00;
  logic [7:0]  rx_b [0:7];
  int          rd_cnt = 0, rx_off = 0;
  logic [2:0]  rx_k;
  logic [11:0] wlog[$];
  logic [11:0] elog[$];
  int          total = 0, bad = 0;

  assign rx_k = 3'(rd_cnt - rx_off);
  assign wb.wb_ack_i = wb.wb_cyc_o & wb.wb_stb_o;
  assign wb.wb_dat_i = (wb.wb_adr_o == 3'd4) ? sr_val :
                       (wb.wb_adr_o == 3'd3) ? rx_b[rx_k] : 8'h00;

  always @(posedge clk)
    if (wb.wb_cyc_o && wb.wb_stb_o && wb.wb_ack_i) begin
      wlog.push_back({wb.wb_we_o, wb.wb_adr_o, wb.wb_we_o ? wb.wb_dat_o : 8'h00});
      if (!wb.wb_we_o && wb.wb_adr_o == 3'd3) rd_cnt++;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic ew(input logic [2:0] a, input logic [7:0] d); elog.push_back({1'b1, a, d}); endtask
  task automatic er(input logic [2:0] a); elog.push_back({1'b0, a, 8'h00}); endtask

  task automatic cmp_log(input string tag, input int base);
    chk({tag, "_len"}, 32'(wlog.size() - base), 32'(elog.size()));
    for (int i = 0; i < elog.size(); i++)
      chk($sformatf("%s[%0d]", tag, i),
          32'((base + i < wlog.size()) ? wlog[base + i] : 12'hFFF), 32'(elog[i]));
    elog.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {18'd0, gnt, done, err, init_done, busy, wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o,
              wb.wb_adr_o}, 32'd0);
    chk({tag, "_dat"}, {24'd0, wb.wb_dat_o}, 32'd0);
    chk({tag, "_rdat"}, rdat, 32'd0);
  endtask

  task automatic setf(input int g, input logic [6:0] a, input logic rw, input logic [1:0] l,
                      input logic [31:0] wd);
    addr[g*7 +: 7] = a; rnw[g] = rw; len[g*2 +: 2] = l; wdat[g*32 +: 32] = wd;
  endtask

  task automatic wait_any(output logic [1:0] d, output logic e, output logic [1:0] gs);
    bit seen;
    d = 2'b00; e = 1'b0; gs = 2'b00; seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) gs = gnt;
      if (done != 2'b00) begin d = done; e = err[0] | err[1]; seen = 1'b1; end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic single(input int g, input logic [6:0] a, input logic rw, input logic [1:0] l,
                        input logic [31:0] wd, output logic [1:0] d, output logic e,
                        output logic [1:0] gs);
    setf(g, a, rw, l, wd);
    req[g] = 1'b1;
    wait_any(d, e, gs);
    req[g] = 1'b0;
  endtask

  logic [1:0] d, gs;
  logic       e;
  int         base;

  initial begin
    for (int i = 0; i < 8; i++) rx_b[i] = 8'(8'h11 * (i + 1));

    // reset and init sequence
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    for (int i = 0; i < 50 && !init_done; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("init_done", 32'(init_done), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);
    ew(3'd0, 8'hC7); ew(3'd1, 8'h00); ew(3'd2, 8'h80);
    cmp_log("init", 0);

    // req0 write, 2 bytes
    base = wlog.size(); sr_val = 8'h00;
    single(0, 7'h4A, 1'b0, 2'd1, 32'h0000BEEF, d, e, gs);
    chk("wr_done", 32'(d), 32'd1); chk("wr_err", 32'(e), 32'd0); chk("wr_gnt", 32'(gs), 32'd1);
    ew(3'd3, 8'h94); ew(3'd4, 8'h90); er(3'd4);
    ew(3'd3, 8'hEF); ew(3'd4, 8'h10); er(3'd4);
    ew(3'd3, 8'hBE); ew(3'd4, 8'h50); er(3'd4); er(3'd4);
    cmp_log("wr", base);

    // req1 read, 3 bytes
    base = wlog.size(); rx_off = rd_cnt;
    single(1, 7'h50, 1'b1, 2'd2, 32'h0, d, e, gs);
    chk("rd_done", 32'(d), 32'd2); chk("rd_err", 32'(e), 32'd0); chk("rd_gnt", 32'(gs), 32'd2);
    chk("rd_rdat", rdat, 32'h00332211);
    ew(3'd3, 8'hA1); ew(3'd4, 8'h90); er(3'd4);
    ew(3'd4, 8'h20); er(3'd4); er(3'd3);
    ew(3'd4, 8'h20); er(3'd4); er(3'd3);
    ew(3'd4, 8'h68); er(3'd4); er(3'd3); er(3'd4);
    cmp_log("rd", base);

    // address NACK: STOP issued, no data bytes
    base = wlog.size(); sr_val = 8'h80;
    single(0, 7'h10, 1'b0, 2'd0, 32'h55, d, e, gs);
    chk("nack_done", 32'(d), 32'd1); chk("nack_err", 32'(e), 32'd1);
    ew(3'd3, 8'h20); ew(3'd4, 8'h90); er(3'd4); ew(3'd4, 8'h40); er(3'd4);
    cmp_log("nack", base);

    // arbitration lost: no STOP write
    base = wlog.size(); sr_val = 8'h20;
    single(1, 7'h33, 1'b0, 2'd0, 32'h55, d, e, gs);
    chk("al_done", 32'(d), 32'd2); chk("al_err", 32'(e), 32'd1);
    ew(3'd3, 8'h66); ew(3'd4, 8'h90); er(3'd4);
    cmp_log("al", base);

    // simultaneous requests, twice: last grant was req1, so req0 goes first
    sr_val = 8'h00;
    setf(0, 7'h01, 1'b0, 2'd0, 32'hA5); setf(1, 7'h02, 1'b0, 2'd0, 32'h5A);
    for (int r = 0; r < 2; r++) begin
      req = 2'b11;
      wait_any(d, e, gs); chk($sformatf("tie%0d_a", r), 32'(gs), 32'd1);
      req = req & ~d;
      wait_any(d, e, gs); chk($sformatf("tie%0d_b", r), 32'(gs), 32'd2);
      req = req & ~d;
    end

    // TIP stuck: TMO+1 status reads, then STOP
    base = wlog.size(); sr_val = 8'h02;
    single(0, 7'h4A, 1'b0, 2'd0, 32'h1, d, e, gs);
    chk("tmo_done", 32'(d), 32'd1); chk("tmo_err", 32'(e), 32'd1);
    ew(3'd3, 8'h94); ew(3'd4, 8'h90);
    for (int i = 0; i <= int'(TMO); i++) er(3'd4);
    ew(3'd4, 8'h40); er(3'd4);
    cmp_log("tmo", base);

    // reset during a 4-byte read, then re-init and re-service
    sr_val = 8'h00; rx_off = rd_cnt; base = wlog.size();
    setf(1, 7'h50, 1'b1, 2'd3, 32'h0);
    req[1] = 1'b1;
    for (int i = 0; i < 200 && wlog.size() < base + 6; i++) @(negedge clk);
    chk("mid_reached", 32'(wlog.size() >= base + 6), 32'd1);
    rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk);
    rx_off = rd_cnt; base = wlog.size();
    rst_n = 1'b1;
    wait_any(d, e, gs);
    req[1] = 1'b0;
    chk("rr_done", 32'(d), 32'd2); chk("rr_err", 32'(e), 32'd0);
    chk("rr_rdat", rdat, 32'h44332211);
    ew(3'd0, 8'hC7); ew(3'd1, 8'h00); ew(3'd2, 8'h80);
    ew(3'd3, 8'hA1); ew(3'd4, 8'h90); er(3'd4);
    for (int i = 0; i < 3; i++) begin ew(3'd4, 8'h20); er(3'd4); er(3'd3); end
    ew(3'd4, 8'h68); er(3'd4); er(3'd3); er(3'd4);
    cmp_log("rr", base);

    repeat (3) @(negedge clk);
    chk("end_idle", {30'd0, busy, wb.wb_cyc_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
